mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/riscv151_mem_pkg.sv | 14 +
 rtl/mem_arb_starve_ctr.sv | 31 +++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv151_mem_pkg.sv
// Shared types and defaults for the RISC-V 151 memory port arbiter slice.
package riscv151_mem_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH   = 12;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    // Owner of the BRAM port in the previous cycle, i.e. whose response is on mem_rdata now.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch requester was denied the port.
module mem_arb_starve_ctr
    import riscv151_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic f_req_valid,
    input  logic f_grant,
    output logic starved
);

    localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!f_req_valid || f_grant) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign starved = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one sync-read BRAM port; data wins unless fetch is starved.
module mem_port_arbiter
    import riscv151_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  f_req_valid,
    output logic                  f_req_ready,
    input  logic [ADDR_WIDTH-1:0] f_req_addr,
    output logic                  f_resp_valid,
    output logic [31:0]           f_resp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [3:0]            d_req_we,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_resp_valid,
    output logic [31:0]           d_resp_data,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    owner_e state;
    owner_e next_state;
    logic   f_grant;
    logic   d_grant;
    logic   starved;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req_valid (f_req_valid),
        .f_grant     (f_grant),
        .starved     (starved)
    );

    // Grants are gated by rst_n so nothing is granted or written while reset is held.
    always_comb begin
        f_grant    = rst_n && f_req_valid && (!d_req_valid || starved);
        d_grant    = rst_n && d_req_valid && !f_grant;
        next_state = IDLE;
        if (f_grant) begin
            next_state = FETCH;
        end else if (d_grant) begin
            next_state = DATA;
        end
    end

    assign f_req_ready = f_grant;
    assign d_req_ready = d_grant;

    always_comb begin
        mem_en    = f_grant || d_grant;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_grant) begin
            mem_we    = d_req_we;
            mem_addr  = d_req_addr;
            mem_wdata = d_req_wdata;
        end else if (f_grant) begin
            mem_addr  = f_req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Response valids decode the registered owner; data comes straight from the BRAM.
    assign f_resp_valid = (state == FETCH);
    assign d_resp_valid = (state == DATA);
    assign f_resp_data  = mem_rdata;
    assign d_resp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW    = 12;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req_valid, f_req_ready, f_resp_valid;
    logic [AW-1:0] f_req_addr;
    logic [31:0]   f_resp_data;
    logic          d_req_valid, d_req_ready, d_resp_valid;
    logic [AW-1:0] d_req_addr;
    logic [3:0]    d_req_we;
    logic [31:0]   d_req_wdata, d_resp_data;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_req_valid  (f_req_valid),
        .f_req_ready  (f_req_ready),
        .f_req_addr   (f_req_addr),
        .f_resp_valid (f_resp_valid),
        .f_resp_data  (f_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wdata  (d_req_wdata),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment BRAM: read-first, one-cycle read latency, byte-enabled writes.
    logic [31:0] bram [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= bram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          starve;
    int          pend_owner;     // 0 none, 1 fetch, 2 data
    logic        pend_is_load;
    logic [31:0] pend_data;
    logic        last_f_grant, last_d_grant;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // One arbitration cycle: called at a negedge, returns at the following negedge.
    task automatic cycle(input logic fv, input logic [AW-1:0] fa, input logic dv,
                         input logic [AW-1:0] da, input logic [3:0] we, input logic [31:0] wd);
        logic ef, ed;
        f_req_valid = fv; f_req_addr = fa;
        d_req_valid = dv; d_req_addr = da; d_req_we = we; d_req_wdata = wd;
        #1;
        ef = fv && (!dv || starve >= LIMIT);
        ed = dv && !ef;
        check("f_ready", {31'b0, f_req_ready}, {31'b0, ef});
        check("d_ready", {31'b0, d_req_ready}, {31'b0, ed});
        check("mem_en", {31'b0, mem_en}, {31'b0, ef || ed});
        check("mem_we", {28'b0, mem_we}, {28'b0, ed ? we : 4'b0000});
        if (ef) check("mem_addr_f", {20'b0, mem_addr}, {20'b0, fa});
        if (ed) begin
            check("mem_addr_d", {20'b0, mem_addr}, {20'b0, da});
            if (we != 4'b0000) check("mem_wdata", mem_wdata, wd);
        end
        check("f_resp_valid", {31'b0, f_resp_valid}, {31'b0, pend_owner == 1});
        check("d_resp_valid", {31'b0, d_resp_valid}, {31'b0, pend_owner == 2});
        if (pend_owner == 1) check("f_resp_data", f_resp_data, pend_data);
        if (pend_owner == 2 && pend_is_load) check("d_resp_data", d_resp_data, pend_data);
        @(posedge clk);
        pend_owner = ef ? 1 : (ed ? 2 : 0);
        pend_is_load = (we == 4'b0000);
        if (ef) pend_data = ref_mem[fa];
        else if (ed) begin
            pend_data = ref_mem[da];
            ref_mem[da] = merge(ref_mem[da], wd, we);
        end
        starve = (fv && !ef) ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        last_f_grant = ef;
        last_d_grant = ed;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, 4'b0000, '0);
    endtask

    logic          rf_v, rd_v;
    logic [AW-1:0] rf_a, rd_a;
    logic [3:0]    rd_we;
    logic [31:0]   rd_wd;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = $urandom;
            ref_mem[i] = bram[i];
        end
        starve = 0; pend_owner = 0; pend_is_load = 1'b1; pend_data = '0;
        last_f_grant = 1'b0; last_d_grant = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 12'h005;
        d_req_valid = 1'b1; d_req_addr = 12'h006; d_req_we = 4'b1111; d_req_wdata = '1;

        // Requests held during reset must not be granted or written.
        repeat (3) @(negedge clk);
        #1;
        check("rst_f_ready", {31'b0, f_req_ready}, 32'd0);
        check("rst_d_ready", {31'b0, d_req_ready}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_we", {28'b0, mem_we}, 32'd0);
        check("rst_resp_v", {30'b0, f_resp_valid, d_resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch stream 0x010..0x013
        for (int i = 0; i < 4; i++) cycle(1'b1, AW'(12'h010 + i), 1'b0, '0, 4'b0000, '0);
        idle();

        // Full store then load
        cycle(1'b0, '0, 1'b1, 12'h020, 4'b1111, 32'hDEADBEEF);
        cycle(1'b0, '0, 1'b1, 12'h020, 4'b0000, '0);
        #1 check("load_deadbeef", d_resp_data, 32'hDEADBEEF);
        #0 check("store_ack_then_load", {31'b0, d_resp_valid}, 32'd1);
        @(negedge clk);
        idle();

        // Byte-lane store
        cycle(1'b0, '0, 1'b1, 12'h030, 4'b1111, 32'h11223344);
        cycle(1'b0, '0, 1'b1, 12'h030, 4'b0010, 32'h0000AB00);
        cycle(1'b0, '0, 1'b1, 12'h030, 4'b0000, '0);
        #1 check("byte_merge", d_resp_data, 32'h1122AB44);
        @(negedge clk);
        idle();

        // Starvation pattern: fetch wins on cycles 4 and 9.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 12'h040, 1'b1, AW'(12'h050 + i), 4'b0000, '0);
            check("starve_pattern", {31'b0, last_f_grant}, {31'b0, i == 4 || i == 9});
        end
        idle();

        // Reset in the cycle after a fetch grant discards the pending response.
        cycle(1'b1, 12'h011, 1'b0, '0, 4'b0000, '0);
        rst_n = 1'b0;
        #1;
        check("rst_drop_f_resp", {31'b0, f_resp_valid}, 32'd0);
        check("rst_mid_mem_en", {31'b0, mem_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pend_owner = 0; starve = 0;
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        #1;
        check("post_rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("post_rst_f_resp", {31'b0, f_resp_valid}, 32'd0);
        @(negedge clk);
        idle();

        // Random traffic; a denied requester holds its request unchanged.
        rf_v = 1'b0; rd_v = 1'b0; rf_a = '0; rd_a = '0; rd_we = '0; rd_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(rf_v && !last_f_grant)) begin
                rf_v = ($urandom_range(0, 3) != 0);
                rf_a = AW'($urandom_range(0, 63));
            end
            if (!(rd_v && !last_d_grant)) begin
                rd_v  = ($urandom_range(0, 2) != 0);
                rd_a  = AW'($urandom_range(0, 63));
                rd_we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0000;
                rd_wd = $urandom;
            end
            cycle(rf_v, rf_a, rd_v, rd_a, rd_we, rd_wd);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
